axis_out_packer: RTL

Parametrised AXI4-Stream master output stage for quantized results, and the next generation of the single-register output stage. Packs RATIO = DATA_BYTES/IN_LANES narrow INT8 result vectors into one AXI beat. Buffers completed beats in a DEPTH-entry FIFO. Emits a partial final beat with TKEEP masking, and keeps throughput and stall statistics for the host. Sits between quantize_unit and the SoC output DMA.

---
 rtl/axis_out_packer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_out_packer.sv
// axis_out_packer: packs RATIO narrow INT8 vectors into one AXI4-Stream beat,
// queues finished beats in a first-word-fall-through FIFO, and keeps
// beat/stall statistics for the host.

// One accumulator slot of the beat under construction. Slot IDX takes the
// incoming word when it is the current write slot, keeps its accumulated
// word when it was already filled, and reads as zero above the write slot.
module axis_out_packer_slot #(
  parameter int IN_LANES = 4,
  parameter int KW       = 1,
  parameter int IDX      = 0
) (
  input  logic [KW-1:0]         k_i,
  input  logic [8*IN_LANES-1:0] in_data_i,
  input  logic [8*IN_LANES-1:0] acc_i,
  output logic [8*IN_LANES-1:0] data_o,
  output logic [IN_LANES-1:0]   keep_o
);
  localparam logic [KW-1:0] MY_K = KW'(IDX);

  // Slot contents and byte enables for a beat closing at slot k_i
  always_comb begin
    data_o = '0;
    if (k_i == MY_K)     data_o = in_data_i;
    else if (MY_K < k_i) data_o = acc_i;
    keep_o = {IN_LANES{MY_K <= k_i}};
  end
endmodule

module axis_out_packer #(
  parameter int IN_LANES   = 4,
  parameter int DATA_BYTES = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [8*IN_LANES-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [8*DATA_BYTES-1:0]      m_axis_tdata,
  output logic [DATA_BYTES-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  input  logic                         clr_stats,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [CNT_W-1:0]             beat_count,
  output logic [CNT_W-1:0]             stall_cycles,
  output logic                         backpressure
);
  localparam int RATIO = DATA_BYTES / IN_LANES;
  localparam int KW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IW    = 8 * IN_LANES;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [DATA_BYTES-1:0] keep;
    logic                  last;
  } beat_t;

  // ---------------- packer ----------------
  logic [RATIO-1:0][IW-1:0]       acc_q, acc_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [RATIO-1:0][IW-1:0]       beat_data;
  logic [RATIO-1:0][IN_LANES-1:0] beat_keep;
  logic                           accept, close, push, pop;
  beat_t                          push_beat;

  for (genvar j = 0; j < RATIO; j++) begin : g_slot
    axis_out_packer_slot #(
      .IN_LANES(IN_LANES),
      .KW      (KW),
      .IDX     (j)
    ) u_slot (
      .k_i      (k_q),
      .in_data_i(in_data),
      .acc_i    (acc_q[j]),
      .data_o   (beat_data[j]),
      .keep_o   (beat_keep[j])
    );
  end

  assign accept = in_valid && in_ready;
  assign close  = (k_q == KW'(RATIO - 1)) || in_last;
  assign push   = accept && close;
  assign pop    = m_axis_tvalid && m_axis_tready;

  always_comb begin
    push_beat.data = beat_data;
    push_beat.keep = beat_keep;
    push_beat.last = in_last;
  end

  // Next slot index and accumulator: fill slot k, or clear once the beat closes
  always_comb begin
    acc_d = acc_q;
    k_d   = k_q;
    if (accept) begin
      if (close) begin
        acc_d = '0;
        k_d   = '0;
      end else begin
        for (int j = 0; j < RATIO; j++)
          if (KW'(j) == k_q) acc_d[j] = in_data;
        k_d = k_q + 1'b1;
      end
    end
  end

  // Packer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      k_q   <= '0;
    end else begin
      acc_q <= acc_d;
      k_q   <= k_d;
    end
  end

  // ---------------- beat FIFO ----------------
  beat_t         mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  beat_t         head;

  // Storage is not reset: entries are only visible while the level says so
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_beat;
  end

  // Pointer and level update; pointers wrap naturally as DEPTH is a power of two
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // FIFO control register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Output view of the head entry; zero whenever nothing is queued
  always_comb begin
    head          = mem_q[rd_q];
    m_axis_tvalid = (lvl_q != '0);
    m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    m_axis_tkeep  = m_axis_tvalid ? head.keep : '0;
    m_axis_tlast  = m_axis_tvalid ? head.last : 1'b0;
  end

  // Ready depends only on the registered level, never on m_axis_tready
  assign in_ready     = (lvl_q != LW'(DEPTH));
  assign fifo_level   = lvl_q;
  assign backpressure = m_axis_tvalid && !m_axis_tready;

  // ---------------- statistics ----------------
  logic [CNT_W-1:0] beats_q, beats_d, stall_q, stall_d;

  // Beat counter wraps, stall counter saturates, clear overrides both
  always_comb begin
    beats_d = beats_q;
    stall_d = stall_q;
    if (pop) beats_d = beats_q + 1'b1;
    if (backpressure && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (clr_stats) begin
      beats_d = '0;
      stall_d = '0;
    end
  end

  // Statistics register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  assign beat_count   = beats_q;
  assign stall_cycles = stall_q;
endmodule
